// File: rtl/i2s_pkg.sv
// i2s_pkg: shared receiver state encoding, channel codes and default sample width
package i2s_pkg;
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} rx_state_t;
  localparam logic I2S_LEFT = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;
  localparam int I2S_SAMPLE_WIDTH = 16;
endpackage

// File: rtl/i2s_edge_sync.sv
// i2s_edge_sync: synchronises SCK/WS/DATA onto CLK and flags SCK rising edges
module i2s_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic Reset,
  input  logic i_sck,
  input  logic i_ws,
  input  logic i_data,
  output logic o_sck_rise,
  output logic o_ws_s,
  output logic o_data_s
);
  logic [SYNC_STAGES-1:0] r_sck, r_ws, r_data;
  logic r_sck_prev;
  // WS and DATA are re-registered so they stay aligned with the registered rise flag
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_sck <= '0;
      r_ws <= '0;
      r_data <= '0;
      r_sck_prev <= 1'b0;
      o_sck_rise <= 1'b0;
      o_ws_s <= 1'b0;
      o_data_s <= 1'b0;
    end else begin
      r_sck <= {r_sck[SYNC_STAGES-2:0], i_sck};
      r_ws <= {r_ws[SYNC_STAGES-2:0], i_ws};
      r_data <= {r_data[SYNC_STAGES-2:0], i_data};
      r_sck_prev <= r_sck[SYNC_STAGES-1];
      o_sck_rise <= r_sck[SYNC_STAGES-1] & ~r_sck_prev;
      o_ws_s <= r_ws[SYNC_STAGES-1];
      o_data_s <= r_data[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S slave receiver emitting stereo frames over valid/ready.
// Optional clock-loss watchdog and ClockLost port enabled by I2S_RX_TIMEOUT_EN.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
  parameter int SYNC_STAGES = 2
`ifdef I2S_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    ADC_I2S_CLK,
  input  logic                    ADC_I2S_WS,
  input  logic                    ADC_I2S_DATA,
  output logic [SAMPLE_WIDTH-1:0] SampleLeft,
  output logic [SAMPLE_WIDTH-1:0] SampleRight,
  output logic                    SampleValid,
  input  logic                    SampleReady,
  output logic                    Locked,
  output logic                    Overrun,
  input  logic                    OverrunClear
`ifdef I2S_RX_TIMEOUT_EN
  , output logic                  ClockLost
`endif
);
  localparam int W = SAMPLE_WIDTH;
  localparam int CW = 6;
  logic w_rise, w_ws, w_data, w_edge, w_take, w_emit, w_to;
  logic [CW-1:0] r_cnt, w_n;
  logic [W-1:0] r_sh, r_lw, w_sh, w_word;
  logic r_ws_prev;
  rx_state_t r_state, w_state_n;

  i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK(CLK), .Reset(Reset), .i_sck(ADC_I2S_CLK), .i_ws(ADC_I2S_WS), .i_data(ADC_I2S_DATA),
    .o_sck_rise(w_rise), .o_ws_s(w_ws), .o_data_s(w_data)
  );

  assign w_edge = w_rise & (w_ws ^ r_ws_prev);
  assign w_take = r_cnt < CW'(W);
  assign w_sh = w_take ? {r_sh[W-2:0], w_data} : r_sh;
  assign w_n = w_take ? r_cnt + 1'b1 : r_cnt;
  // left-justify short slots so missing LSBs read as zero
  assign w_word = w_sh << (CW'(W) - w_n);
  assign w_emit = w_edge & (r_state == RIGHT);

`ifdef I2S_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_to;
  assign w_to = (r_to == TW'(TIMEOUT_CYCLES - 1)) & ~w_rise;
`else
  assign w_to = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    if (w_edge) w_state_n = r_state == LEFT ? RIGHT : (r_state == RIGHT || w_ws == I2S_LEFT) ? LEFT : IDLE;
    if (w_to) w_state_n = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= IDLE;
    else r_state <= w_state_n;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_cnt <= '0;
      r_sh <= '0;
      r_lw <= '0;
      r_ws_prev <= 1'b0;
      SampleLeft <= '0;
      SampleRight <= '0;
      SampleValid <= 1'b0;
      Locked <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      if (w_rise) begin
        r_ws_prev <= w_ws;
        r_cnt <= w_edge ? '0 : w_n;
        r_sh <= w_edge ? '0 : w_sh;
      end
      if (w_edge && r_state == LEFT) begin
        r_lw <= w_word;
        Locked <= 1'b1;
      end
      if (w_emit && (!SampleValid || SampleReady)) begin
        SampleLeft <= r_lw;
        SampleRight <= w_word;
        SampleValid <= 1'b1;
      end else if (SampleValid && SampleReady) SampleValid <= 1'b0;
      Overrun <= (w_emit & SampleValid & ~SampleReady) | (Overrun & ~OverrunClear);
      if (w_to) begin
        r_cnt <= '0;
        r_sh <= '0;
        Locked <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_to <= '0;
      ClockLost <= 1'b0;
    end else begin
      r_to <= (w_rise || w_to) ? '0 : r_to + 1'b1;
      if (w_to) ClockLost <= 1'b1;
    end
  end
`endif
endmodule
